// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the multiplier operand sequencer
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    localparam int DEF_WIDTH   = 5;
    localparam int DEF_LATENCY = 2;
    // Wide enough for any LATENCY in 1..15
    localparam int CNT_W       = 4;
    localparam int ACC_W       = 2 * DEF_WIDTH + 4;

endpackage

// File: rtl/mul_latency_counter.sv
// rtl/mul_latency_counter.sv - loadable down-counter with enable and zero flag
module mul_latency_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/mul_operand_sequencer.sv
// rtl/mul_operand_sequencer.sv - operand capture, latency wait and product hold for the array multiplier (option: MUL_SEQ_ACCUM_EN)
module mul_operand_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [WIDTH-1:0]     op_in,
    input  logic                 load_a,
    input  logic                 load_b,
    input  logic                 start,
    input  logic                 ack,
    input  logic [2*WIDTH-1:0]   prod_in,
`ifdef MUL_SEQ_ACCUM_EN
    input  logic                 acc_clr,
    output logic [2*WIDTH+3:0]   acc_out,
`endif
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    mul_state_e state_q, state_d;

    logic             open_q;
    logic             launch;
    logic             capture;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] result_q;

    // Operands may only change while nothing is in flight
    assign open_q  = (state_q == IDLE) || (state_q == DONE);
    assign launch  = ena && start && open_q;
    assign capture = ena && (state_q == WAIT) && cnt_zero;

    mul_latency_counter #(
        .W (CNT_W)
    ) u_latency_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ena && (state_q == WAIT)),
        .load     (launch),
        .load_val (CNT_INIT),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (launch) state_d = WAIT;
            end
            WAIT: begin
                if (capture) state_d = DONE;
            end
            DONE: begin
                // start wins over a simultaneous ack
                if (launch)          state_d = WAIT;
                else if (ena && ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            if (ena && open_q && load_a) a_q <= op_in;
            if (ena && open_q && load_b) b_q <= op_in;
            if (capture)                 result_q <= prod_in;
        end
    end

`ifdef MUL_SEQ_ACCUM_EN
    localparam int AW = 2 * WIDTH + 4;

    logic [AW-1:0] acc_q;
    logic [AW-1:0] prod_ext;
    logic [AW:0]   acc_sum;
    logic [AW-1:0] acc_sat;

    assign prod_ext = {{(AW - 2*WIDTH){1'b0}}, prod_in};
    assign acc_sum  = {1'b0, acc_q} + {1'b0, prod_ext};
    assign acc_sat  = acc_sum[AW] ? {AW{1'b1}} : acc_sum[AW-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (ena) begin
            // Clear restarts the running total from this product if one lands now
            if (acc_clr)      acc_q <= capture ? prod_ext : '0;
            else if (capture) acc_q <= acc_sat;
        end
    end

    assign acc_out = acc_q;
`endif

    assign mul_a  = a_q;
    assign mul_b  = b_q;
    assign result = result_q;
    assign busy   = (state_q == WAIT);
    assign done   = (state_q == DONE);

    logic unused_cnt;
    assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// tb/tb_mul_operand_sequencer.sv - directed self-checking bench for mul_operand_sequencer
module tb_mul_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, ena, load_a, load_b, start, ack;
    logic [4:0] op_in;
    logic [9:0] prod_in;
    logic [4:0] mul_a, mul_b;
    logic [9:0] result;
    logic       busy, done;
`ifdef MUL_SEQ_ACCUM_EN
    logic        acc_clr;
    logic [13:0] acc_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Core model: product valid one cycle after operands change, inside the 2-cycle window
    always @(posedge clk) prod_in <= {5'd0, mul_a} * {5'd0, mul_b};

    mul_operand_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .op_in   (op_in),
        .load_a  (load_a),
        .load_b  (load_b),
        .start   (start),
        .ack     (ack),
        .prod_in (prod_in),
`ifdef MUL_SEQ_ACCUM_EN
        .acc_clr (acc_clr),
        .acc_out (acc_out),
`endif
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .result  (result),
        .busy    (busy),
        .done    (done)
    );

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic [9:0] p;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_mul(input logic [4:0] a, input logic [4:0] b, output int cyc);
        op_in = a; load_a = 1'b1; tick(); load_a = 1'b0;
        op_in = b; load_b = 1'b1; tick(); load_b = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;

        tbl[0] = '{a: 5'd5,  b: 5'd7,  p: 10'd35};
        tbl[1] = '{a: 5'd31, b: 5'd31, p: 10'd961};
        tbl[2] = '{a: 5'd0,  b: 5'd17, p: 10'd0};
        tbl[3] = '{a: 5'd1,  b: 5'd31, p: 10'd31};
        tbl[4] = '{a: 5'd16, b: 5'd16, p: 10'd256};
        tbl[5] = '{a: 5'd3,  b: 5'd4,  p: 10'd12};

        rst_n = 1'b0; ena = 1'b1; load_a = 1'b0; load_b = 1'b0;
        start = 1'b0; ack = 1'b0; op_in = 5'd0;
`ifdef MUL_SEQ_ACCUM_EN
        acc_clr = 1'b0;
`endif
        tick(); tick();
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_mul_a",  32'(mul_a),  32'd0);
        chk("rst_mul_b",  32'(mul_b),  32'd0);
        rst_n = 1'b1;
        tick();

        // First multiply with cycle-exact latency
        op_in = 5'd5; load_a = 1'b1; tick(); load_a = 1'b0;
        op_in = 5'd7; load_b = 1'b1; tick(); load_b = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("lat_busy_n1", 32'(busy), 32'd1);
        chk("lat_done_n1", 32'(done), 32'd0);
        tick();
        chk("lat_busy_n2", 32'(busy), 32'd1);
        chk("lat_done_n2", 32'(done), 32'd0);
        tick();
        chk("lat_busy_n3", 32'(busy),   32'd0);
        chk("lat_done_n3", 32'(done),   32'd1);
        chk("lat_result",  32'(result), 32'd35);
        chk("lat_mul_a",   32'(mul_a),  32'd5);
        chk("lat_mul_b",   32'(mul_b),  32'd7);
        ack = 1'b1; tick(); ack = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_mul(tbl[i].a, tbl[i].b, cyc);
            chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'd2);
            chk($sformatf("vec%0d_result", i), 32'(result), 32'(tbl[i].p));
            chk($sformatf("vec%0d_mul_a", i),  32'(mul_a),  32'(tbl[i].a));
            tick();
            chk($sformatf("vec%0d_hold", i),   32'(result), 32'(tbl[i].p));
            chk($sformatf("vec%0d_done_held", i), 32'(done), 32'd1);
            if (i == 5) break;
            ack = 1'b1; tick(); ack = 1'b0;
            chk($sformatf("vec%0d_ack_done", i), 32'(done), 32'd0);
            chk($sformatf("vec%0d_ack_idle", i), 32'(busy), 32'd0);
            chk($sformatf("vec%0d_ack_keep", i), 32'(result), 32'(tbl[i].p));
        end

        // In DONE with 3*4: load_a=6 together with start, no IDLE gap
        op_in = 5'd6; load_a = 1'b1; start = 1'b1; tick();
        load_a = 1'b0; start = 1'b0;
        chk("b2b_busy",  32'(busy),  32'd1);
        chk("b2b_done",  32'(done),  32'd0);
        chk("b2b_mul_a", 32'(mul_a), 32'd6);
        tick(); tick();
        chk("b2b_done2",  32'(done),   32'd1);
        chk("b2b_result", 32'(result), 32'd24);

        // ack and start together: start wins
        ack = 1'b1; start = 1'b1; tick(); ack = 1'b0; start = 1'b0;
        chk("ackstart_busy", 32'(busy), 32'd1);
        chk("ackstart_done", 32'(done), 32'd0);
        tick(); tick();
        chk("ackstart_fin", 32'(done), 32'd1);
        ack = 1'b1; tick(); ack = 1'b0;

        // WAIT: loads/start ignored, ena low freezes for 3 cycles
        start = 1'b1; tick();
        op_in = 5'd9; load_a = 1'b1; load_b = 1'b1; tick();
        chk("wait_mul_a", 32'(mul_a), 32'd6);
        chk("wait_mul_b", 32'(mul_b), 32'd4);
        ena = 1'b0;
        tick(); tick(); tick();
        chk("frz_busy", 32'(busy), 32'd1);
        chk("frz_done", 32'(done), 32'd0);
        ena = 1'b1; load_a = 1'b0; load_b = 1'b0; start = 1'b0;
        tick();
        chk("frz_done_late", 32'(done),   32'd1);
        chk("frz_result",    32'(result), 32'd24);
        chk("frz_mul_a",     32'(mul_a),  32'd6);
        ack = 1'b1; tick(); ack = 1'b0;

        // Reset in the middle of WAIT
        start = 1'b1; tick(); start = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mrst_busy",   32'(busy),   32'd0);
        chk("mrst_done",   32'(done),   32'd0);
        chk("mrst_result", 32'(result), 32'd0);
        chk("mrst_mul_a",  32'(mul_a),  32'd0);
        chk("mrst_mul_b",  32'(mul_b),  32'd0);
        run_mul(5'd2, 5'd3, cyc);
        chk("mrst_cycles", 32'(cyc),    32'd2);
        chk("mrst_after",  32'(result), 32'd6);
        ack = 1'b1; tick(); ack = 1'b0;

`ifdef MUL_SEQ_ACCUM_EN
        acc_clr = 1'b1; tick(); acc_clr = 1'b0;
        chk("acc_clr0", 32'(acc_out), 32'd0);
        for (int k = 1; k <= 20; k++) begin
            run_mul(5'd31, 5'd31, cyc);
            ack = 1'b1; tick(); ack = 1'b0;
            if (k == 1)  chk("acc_1",  32'(acc_out), 32'd961);
            if (k == 17) chk("acc_17", 32'(acc_out), 32'd16337);
        end
        chk("acc_sat", 32'(acc_out), 32'd16383);
        acc_clr = 1'b1; tick(); acc_clr = 1'b0;
        chk("acc_clr1", 32'(acc_out), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        acc_clr = 1'b1; tick(); acc_clr = 1'b0;
        chk("acc_clr_cap_done", 32'(done),    32'd1);
        chk("acc_clr_cap",      32'(acc_out), 32'd961);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
